// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one requester onto a UART transmitter for a
// whole message. A message ends on the byte flagged with req_last. The lock is
// also dropped if the owner stays silent for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_BITS-1:0]         tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned SumW = IdW + 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       grant_q, grant_d;
  logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 last_flag_q, last_flag_d;
  logic [CntW-1:0]      timeout_q, timeout_d;

  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [IdW-1:0]       pick_off;
  logic [SumW-1:0]      pick_sum;
  logic [SumW-1:0]      next_sum;
  logic [IdW-1:0]       pick_id;
  logic [IdW-1:0]       next_ptr;

  logic                 gnt_valid;
  logic                 gnt_last;
  logic [DATA_BITS-1:0] gnt_data;
  logic                 accept;

  // Pick the first valid requester at or above rr_ptr (with wrap), and the
  // pointer value that follows the current grant.
  always_comb begin
    // Rotating right by rr_ptr puts requester rr_ptr at bit 0.
    dbl_valid = {req_valid, req_valid} >> rr_ptr_q;
    rot_valid = dbl_valid[NUM_REQ-1:0];
    pick_off  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot_valid[j]) pick_off = IdW'(j);
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= SumW'(NUM_REQ)) pick_sum = pick_sum - SumW'(NUM_REQ);
    pick_id = pick_sum[IdW-1:0];

    next_sum = {1'b0, grant_q} + SumW'(1);
    if (next_sum >= SumW'(NUM_REQ)) next_sum = '0;
    next_ptr = next_sum[IdW-1:0];
  end

  // Mux out the granted requester's lane.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IdW'(i)) begin
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
        gnt_data  = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Only the lock owner is ready, and only while the output register is empty.
  always_comb begin
    req_ready = '0;
    if (state_q == StLocked && !tx_valid_q) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_q == IdW'(i));
      end
    end
  end

  assign accept = (state_q == StLocked) && !tx_valid_q && gnt_valid;

  // Next-state: arbitration, byte accept, tx handshake and lock timeout.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    last_flag_d = last_flag_q;
    timeout_d   = timeout_q;

    case (state_q)
      StIdle: begin
        if (|req_valid) begin
          grant_d = pick_id;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (accept) begin
          tx_data_d   = gnt_data;
          tx_valid_d  = 1'b1;
          last_flag_d = gnt_last;
          timeout_d   = '0;
        end else if (tx_valid_q) begin
          // Waiting on the transmitter does not count as owner silence.
          if (tx_ready) begin
            tx_valid_d = 1'b0;
            if (last_flag_q) begin
              state_d     = StIdle;
              rr_ptr_d    = next_ptr;
              last_flag_d = 1'b0;
            end
          end
        end else begin
          timeout_d = timeout_q + CntW'(1);
          if (timeout_d == CntW'(TIMEOUT_CYCLES)) begin
            state_d     = StIdle;
            rr_ptr_d    = next_ptr;
            last_flag_d = 1'b0;
            timeout_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      last_flag_q <= 1'b0;
      timeout_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      last_flag_q <= last_flag_d;
      timeout_q   <= timeout_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == StLocked);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning the byte width carried to the transmitter.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the idle cycles allowed mid-message before the lock is dropped.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-006 The block SHALL have port req_data, input, NUM_REQ*DATA_BITS, the per-requester byte; slice i is bits [i*DATA_BITS +: DATA_BITS].
REQ-007 The block SHALL have port req_valid, input, NUM_REQ, meaning requester i offers a byte.
REQ-008 The block SHALL have port req_last, input, NUM_REQ, meaning the offered byte ends requester i's message.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ, meaning the byte of requester i is accepted this cycle.
REQ-010 The block SHALL have port tx_data, output, DATA_BITS, the byte presented to the UART transmitter.
REQ-011 The block SHALL have port tx_valid, output, 1, meaning tx_data holds a byte for the transmitter.
REQ-012 The block SHALL have port tx_ready, input, 1, meaning the transmitter takes tx_data this cycle.
REQ-013 The block SHALL have port grant_id, output, clog2(NUM_REQ), the currently locked requester index.
REQ-014 The block SHALL have port busy, output, 1, meaning the state is LOCKED.

Function
REQ-015 The block SHALL implement two states: IDLE and LOCKED.
REQ-016 In IDLE, when any req_valid bit is set, the block SHALL pick the first set bit at or above (rr_ptr) with wrap-around, load grant_id, and enter LOCKED on the next edge.
REQ-017 In IDLE, req_ready SHALL be all zero, and no byte SHALL be accepted in the arbitration cycle.
REQ-018 In LOCKED, req_ready[i] SHALL be combinationally (i == grant_id) AND NOT tx_valid, and all other req_ready bits SHALL be 0.
REQ-019 A byte SHALL be accepted when req_valid[grant_id] AND req_ready[grant_id]; on that edge tx_data loads the slice, tx_valid becomes 1, and the last_flag register loads req_last[grant_id].
REQ-020 tx_valid SHALL be registered and SHALL remain 1 with tx_data stable until a cycle in which tx_ready is 1; on that edge tx_valid becomes 0.
REQ-021 On a tx_ready handshake with last_flag set, the block SHALL return to IDLE and set rr_ptr to (grant_id+1) mod NUM_REQ.
REQ-022 Latency SHALL be as follows: req_valid is first seen in IDLE at cycle n, req_ready is high at n+1, and tx_valid is high at n+2.
REQ-023 Sustained throughput SHALL be at most one byte per two cycles, which is sufficient for any CYCLES_PER_SYMBOL >= 1 transmitter.
REQ-024 A timeout counter SHALL count cycles in LOCKED with tx_valid=0 and req_valid[grant_id]=0, and it SHALL clear on any accept.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL return to IDLE, advance rr_ptr, and send no byte.
REQ-026 Changes on req_valid of non-granted requesters SHALL have no effect while LOCKED, so no byte interleaving occurs.
REQ-027 If the granted requester asserts req_valid and req_last in the same cycle the lock starts, a single-byte message SHALL result.
REQ-028 req_data and req_last SHALL be sampled only on the accept cycle; changes at other times SHALL be ignored.
REQ-029 If tx_ready is high while tx_valid is 0, it SHALL have no effect.

Reset
REQ-030 rst high SHALL immediately force state=IDLE, tx_valid=0, tx_data=0, req_ready=0, grant_id=0, busy=0, rr_ptr=0, timeout counter=0, and last_flag=0.
REQ-031 If rst is asserted mid-message, any pending tx byte SHALL be discarded, and after release arbitration SHALL restart from requester 0.
REQ-032 Release of rst SHALL be synchronized to clk by the integrating level; the block itself SHALL register no output during rst.

Verification
REQ-033 Scenario: requester 2 alone sends 0xA5 with last=1 and tx_ready tied high -> req_ready[2] pulses once, tx_data=0xA5 is valid for one cycle, busy drops, and rr_ptr=3.
REQ-034 Scenario: all 4 requesters hold valid, each sending a 1-byte message, starting from reset -> grant order is 0,1,2,3,0, and tx bytes appear in that order.
REQ-035 Scenario: requester 1 sends 0x11,0x22,0x33 (last on 0x33) while requester 0 holds valid -> tx emits 0x11,0x22,0x33 with no interleaving, then grant goes to 0 because the pointer wraps to 2,3,0.
REQ-036 Scenario: tx_ready is held low for 20 cycles with tx_valid high -> tx_data stays stable, all req_ready stay 0, and the timeout counter does not advance.
REQ-037 Scenario: TIMEOUT_CYCLES=8, requester 3 sends a byte with last=0 and then drops valid -> after 8 idle cycles busy=0 and requester 0 can be granted.
REQ-038 Scenario: rst is pulsed while tx_valid=1 for byte 0x5A -> tx_valid=0 within the same cycle, and the next grant goes to requester 0.
